// File: rtl/wb_queue_pkg.sv
// Shared types and defaults for the writeback queue and its forwarding lookup.
package wb_queue_pkg;

    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_AW    = 5;
    localparam int unsigned DEF_DW    = 32;

    localparam logic [DEF_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-match search across the output stage and the queue entries (oldest to youngest).
module wb_fwd_lookup
    import wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW
) (
    input  wb_entry_t                  ents_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  wb_entry_t                  out_i,
    input  logic [AW-1:0]              addr_i,
    output logic                       hit_o,
    output logic [DW-1:0]              data_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk from the output stage towards the tail so later matches overwrite older ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        if (addr_i != REG_ZERO) begin
            if (out_i.valid && out_i.addr == addr_i) begin
                hit_o  = 1'b1;
                data_o = out_i.data;
            end
            for (int k = 0; k < int'(DEPTH); k++) begin
                idx = head_i + PW'(k);
                if (ents_i[idx].valid && ents_i[idx].addr == addr_i) begin
                    hit_o  = 1'b1;
                    data_o = ents_i[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers load/ALU register writes in program order and drains one per cycle,
// with a pending-register scoreboard and two forwarding lookups over the buffered writes.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned DW    = DEF_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_addr,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_addr,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    output logic                     regWrite,
    output logic [AW-1:0]            writeAddr,
    output logic [DW-1:0]            writeData,
    input  logic [AW-1:0]            fwdAddr1,
    input  logic [AW-1:0]            fwdAddr2,
    output logic                     fwdHit1,
    output logic                     fwdHit2,
    output logic [DW-1:0]            fwdData1,
    output logic [DW-1:0]            fwdData2,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t     ents_q [DEPTH];
    wb_entry_t     ents_d [DEPTH];
    wb_entry_t     out_q, out_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          mem_push, alu_push, pop;

    // Ready depends on occupancy only, never on the drain side.
    assign mem_ready = count_q < CW'(DEPTH);
    assign mem_push  = mem_valid && mem_ready && (mem_addr != REG_ZERO);
    assign alu_ready = (count_q + CW'(mem_push)) < CW'(DEPTH);
    assign alu_push  = alu_valid && alu_ready && (alu_addr != REG_ZERO);
    assign pop       = count_q != '0;

    assign regWrite  = out_q.valid;
    assign writeAddr = out_q.addr;
    assign writeData = out_q.data;
    assign count     = count_q;

    always_comb begin
        ents_d      = ents_q;
        out_d       = out_q;
        out_d.valid = 1'b0;
        head_d      = head_q;
        if (pop) begin
            out_d               = ents_q[head_q];
            out_d.valid         = 1'b1;
            ents_d[head_q].valid = 1'b0;
            head_d              = head_q + 1'b1;
        end
        // The load is older in program order, so it takes the first free slot.
        if (mem_push) begin
            ents_d[tail_q] = '{valid: 1'b1, addr: mem_addr, data: mem_data};
        end
        if (alu_push) begin
            ents_d[tail_q + PW'(mem_push)] = '{valid: 1'b1, addr: alu_addr, data: alu_data};
        end
        tail_d  = tail_q + PW'(mem_push) + PW'(alu_push);
        count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ents_q[i].valid) pending[ents_q[i].addr] = 1'b1;
        end
        if (out_q.valid) pending[out_q.addr] = 1'b1;
        pending[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ents_q  <= '{default: '0};
            out_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ents_q  <= ents_d;
            out_q   <= out_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    wb_fwd_lookup #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd1 (
        .ents_i (ents_q),
        .head_i (head_q),
        .out_i  (out_q),
        .addr_i (fwdAddr1),
        .hit_o  (fwdHit1),
        .data_o (fwdData1)
    );

    wb_fwd_lookup #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd2 (
        .ents_i (ents_q),
        .head_i (head_q),
        .out_i  (out_q),
        .addr_i (fwdAddr2),
        .hit_o  (fwdHit2),
        .data_o (fwdData2)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: expected register-file writes are queued at issue time and
// popped by an independent monitor; a queue-based reference model checks all other outputs.
module tb_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0, alu_valid = 1'b0;
    logic [4:0]  mem_addr = '0, alu_addr = '0, fwdAddr1 = '0, fwdAddr2 = '0;
    logic [31:0] mem_data = '0, alu_data = '0;
    logic        mem_ready, alu_ready, regWrite, fwdHit1, fwdHit2;
    logic [4:0]  writeAddr;
    logic [31:0] writeData, fwdData1, fwdData2, pending;
    logic [2:0]  count;

    always #5 clk = ~clk;

    wb_queue dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .regWrite  (regWrite),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .fwdAddr1  (fwdAddr1),
        .fwdAddr2  (fwdAddr2),
        .fwdHit1   (fwdHit1),
        .fwdHit2   (fwdHit2),
        .fwdData1  (fwdData1),
        .fwdData2  (fwdData2),
        .pending   (pending),
        .count     (count)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t  mdl_q[$];     // model queue contents, oldest first
    wr_t  exp_wr[$];    // scoreboard of register-file writes in expected order
    logic out_v;
    wr_t  out_s;
    logic take_m, take_a;
    wr_t  new_m, new_a;
    wr_t  mon_w;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_pending();
        logic [31:0] p = '0;
        foreach (mdl_q[i]) p[mdl_q[i].a] = 1'b1;
        if (out_v) p[out_s.a] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    function automatic logic [32:0] mdl_fwd(input logic [4:0] a);
        if (a == 5'd0) return '0;
        for (int i = mdl_q.size() - 1; i >= 0; i--) begin
            if (mdl_q[i].a == a) return {1'b1, mdl_q[i].d};
        end
        if (out_v && out_s.a == a) return {1'b1, out_s.d};
        return '0;
    endfunction

    task automatic drive_check(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic [4:0] f1, input logic [4:0] f2);
        logic        mr, ar;
        logic [32:0] e1, e2;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        fwdAddr1  = f1; fwdAddr2 = f2;
        #1;
        mr     = mdl_q.size() < DEPTH;
        take_m = mv && mr && (ma != 5'd0);
        ar     = (mdl_q.size() + int'(take_m)) < DEPTH;
        take_a = av && ar && (aa != 5'd0);
        e1     = mdl_fwd(f1);
        e2     = mdl_fwd(f2);
        chk("mem_ready", mem_ready, mr);
        chk("alu_ready", alu_ready, ar);
        chk("count", count, mdl_q.size());
        chk("regWrite", regWrite, out_v);
        chk("writeAddr", writeAddr, out_s.a);
        chk("writeData", writeData, out_s.d);
        chk("pending", pending, mdl_pending());
        chk("fwdHit1", fwdHit1, e1[32]);
        chk("fwdData1", fwdData1, e1[31:0]);
        chk("fwdHit2", fwdHit2, e2[32]);
        chk("fwdData2", fwdData2, e2[31:0]);
        new_m = '{a: ma, d: md};
        new_a = '{a: aa, d: ad};
        if (take_m) exp_wr.push_back(new_m);
        if (take_a) exp_wr.push_back(new_a);
    endtask

    task automatic advance();
        @(posedge clk);
        if (mdl_q.size() > 0) begin
            out_s = mdl_q.pop_front();
            out_v = 1'b1;
        end else begin
            out_v = 1'b0;
        end
        if (take_m) mdl_q.push_back(new_m);
        if (take_a) mdl_q.push_back(new_a);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_check(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'($urandom_range(1, 7)), 5'd0);
            advance();
        end
    endtask

    // Scoreboard monitor: every register-file write must match the next expected one.
    always @(negedge clk) begin
        if (rst && regWrite === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got r%0d=%0h expected none", writeAddr, writeData);
            end else begin
                mon_w = exp_wr.pop_front();
                if (writeAddr !== mon_w.a || writeData !== mon_w.d) begin
                    errors++;
                    $display("FAIL write_order: got r%0d=%0h expected r%0d=%0h",
                             writeAddr, writeData, mon_w.a, mon_w.d);
                end
            end
        end
    end

    initial begin
        out_v = 1'b0;
        out_s = '{a: 5'd0, d: 32'd0};
        take_m = 1'b0;
        take_a = 1'b0;
        fwdAddr1 = 5'd5;
        fwdAddr2 = 5'd3;
        #1;
        chk("rst_regWrite", regWrite, 0);
        chk("rst_count", count, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ready", {mem_ready, alu_ready}, 2'b11);
        chk("rst_fwd", {fwdHit1, fwdHit2, fwdData1, fwdData2}, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single push r5 = 0xAA and its pending window.
        drive_check(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAA, 5'd5, 5'd0);
        advance();
        drive_check(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        chk("single_pend_e1", pending[5], 1);
        chk("single_nowrite_e1", regWrite, 0);
        advance();
        drive_check(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        chk("single_write", {regWrite, writeAddr, writeData}, {1'b1, 5'd5, 32'hAA});
        chk("single_pend_e2", pending[5], 1);
        advance();
        drive_check(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        chk("single_pend_e3", pending[5], 0);
        advance();

        // Same-cycle ordering, youngest-match forwarding.
        drive_check(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
        advance();
        drive_check(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        chk("order_fwd", {fwdHit1, fwdData1}, {1'b1, 32'h22});
        advance();
        drive_check(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        chk("order_first", writeData, 32'h11);
        chk("order_fwd_out", fwdData1, 32'h22);
        advance();
        idle(3);

        // Backpressure at count 3.
        drive_check(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 5'd2, 5'd1);
        advance();
        drive_check(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, 5'd4, 5'd3);
        advance();
        drive_check(1'b1, 5'd6, 32'h6, 1'b1, 5'd7, 32'h7, 5'd7, 5'd6);
        chk("bp_count", count, 3);
        chk("bp_ready", {mem_ready, alu_ready}, 2'b10);
        advance();
        drive_check(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h7, 5'd7, 5'd6);
        chk("bp_alu_later", alu_ready, 1);
        advance();
        idle(6);

        // Ten back-to-back pushes exercise pointer wrap.
        for (int i = 0; i < 10; i++) begin
            drive_check(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'(i * 7 + 1), 5'(i + 1), 5'(i));
            advance();
        end
        idle(3);

        // Register 0 is accepted and discarded.
        drive_check(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        chk("r0_ready", alu_ready, 1);
        advance();
        drive_check(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("r0_state", {count, regWrite, pending, fwdHit1}, 0);
        advance();
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive_check(1'($urandom_range(0, 99) < 70), 5'($urandom_range(0, 7)), $urandom,
                        1'($urandom_range(0, 99) < 70), 5'($urandom_range(0, 7)), $urandom,
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            advance();
        end
        idle(6);

        // Reset with three entries queued and a write in the output stage.
        drive_check(1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, 5'd9, 5'd10);
        advance();
        drive_check(1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0, 5'd11, 5'd12);
        advance();
        drive_check(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11, 5'd12);
        chk("pre_rst", {count, regWrite}, {3'd3, 1'b1});
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_out", {regWrite, writeAddr, writeData}, 0);
        chk("midrst_count", count, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_fwd", {fwdHit1, fwdHit2, fwdData1, fwdData2}, 0);
        chk("midrst_ready", {mem_ready, alu_ready}, 2'b11);
        mdl_q.delete();
        exp_wr.delete();
        out_v = 1'b0;
        out_s = '{a: 5'd0, d: 32'd0};
        take_m = 1'b0;
        take_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        drive_check(1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
        advance();
        idle(8);

        chk("drain_all", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
